// File: rtl/iod_rd_eye_trainer.sv
// Read-eye training controller: sweeps each IOD lane's RX delay line, finds the first passing window
// and parks the lane at its centre. Optional macro IOD_RD_TRAIN_MIN_WIN_EN rejects windows narrower than MIN_WIN.
module iod_rd_eye_trainer #(
  parameter int NUM_LANES     = 2,
  parameter int TAP_W         = 7,
  parameter int MAX_TAP       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WIN       = 4
) (
  input  logic                             FAB_CLK,
  input  logic                             ARST_N,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_LANES-1:0]             delay_line_move,
  output logic [NUM_LANES-1:0]             delay_line_direction,
  output logic [NUM_LANES-1:0]             delay_line_load,
  output logic [NUM_LANES-1:0]             eye_clear_flags,
  input  logic [NUM_LANES-1:0]             eye_early,
  input  logic [NUM_LANES-1:0]             eye_late,
  input  logic [NUM_LANES-1:0]             delay_out_of_range,
  output logic [NUM_LANES*TAP_W-1:0]       lane_center,
  output logic [NUM_LANES*(TAP_W+1)-1:0]   lane_width,
  output logic [NUM_LANES-1:0]             lane_err
);

  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef IOD_RD_TRAIN_MIN_WIN_EN
  localparam int WIN_FLOOR = MIN_WIN;
`else
  // A found window is always at least one tap wide, so this floor never rejects.
  localparam int WIN_FLOOR = MIN_WIN - MIN_WIN + 1;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_EVAL,
    S_STEP, S_CLOAD, S_CMOVE, S_NEXT, S_DONE
  } state_t;

  state_t                        state_q;
  logic [LANE_W-1:0]             lane_q;
  logic [TAP_W-1:0]              tap_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          fail_q;
  logic                          oor_q;
  logic                          open_q;
  logic [TAP_W-1:0]              first_q;
  logic [TAP_W-1:0]              last_q;
  logic [TAP_W-1:0]              res_center_q;
  logic [TAP_W:0]                res_width_q;
  logic                          res_err_q;
  logic [TAP_W-1:0]              mv_cnt_q;
  logic [NUM_LANES-1:0]          load_q;
  logic [NUM_LANES-1:0]          move_q;
  logic [NUM_LANES-1:0]          clear_q;
  logic                          busy_q;
  logic                          done_q;
  logic [NUM_LANES*TAP_W-1:0]    center_q;
  logic [NUM_LANES*(TAP_W+1)-1:0] width_q;
  logic [NUM_LANES-1:0]          err_q;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] l);
    return NUM_LANES'(1) << l;
  endfunction

  function automatic logic [TAP_W:0] win_width(input logic [TAP_W-1:0] f, input logic [TAP_W-1:0] l);
    return {1'b0, l} - {1'b0, f} + (TAP_W+1)'(1);
  endfunction

  // Floor of the midpoint; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [TAP_W-1:0] win_center(input logic [TAP_W-1:0] f, input logic [TAP_W-1:0] l);
    logic [TAP_W:0] s;
    s = {1'b0, f} + {1'b0, l};
    return TAP_W'(s >> 1);
  endfunction

  logic             pass_c, closed_c, sweep_end_c, found_c;
  logic             open_d;
  logic [TAP_W-1:0] first_d, last_d, center_c;
  logic [TAP_W:0]   width_c;

  always_comb begin
    pass_c   = ~fail_q;
    open_d   = open_q;
    first_d  = first_q;
    last_d   = last_q;
    closed_c = 1'b0;
    if (pass_c) begin
      if (!open_q) begin
        first_d = tap_q;
        open_d  = 1'b1;
      end
      last_d = tap_q;
    end else if (open_q) begin
      open_d   = 1'b0;
      closed_c = 1'b1;
    end
    sweep_end_c = (tap_q == TAP_W'(MAX_TAP)) || oor_q;
    found_c     = closed_c || (open_d && sweep_end_c);
    width_c     = win_width(first_d, last_d);
    center_c    = win_center(first_d, last_d);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      fail_q       <= 1'b0;
      oor_q        <= 1'b0;
      open_q       <= 1'b0;
      first_q      <= '0;
      last_q       <= '0;
      res_center_q <= '0;
      res_width_q  <= '0;
      res_err_q    <= 1'b0;
      mv_cnt_q     <= '0;
      load_q       <= '0;
      move_q       <= '0;
      clear_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      center_q     <= '0;
      width_q      <= '0;
      err_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            lane_q   <= '0;
            tap_q    <= '0;
            open_q   <= 1'b0;
            load_q   <= lane_onehot('0);
            center_q <= '0;
            width_q  <= '0;
            err_q    <= '0;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD, S_STEP: begin
          if (state_q == S_STEP) tap_q <= tap_q + TAP_W'(1);
          load_q  <= '0;
          move_q  <= '0;
          cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            clear_q <= lane_onehot(lane_q);
            state_q <= S_CLEAR;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CLEAR: begin
          clear_q <= '0;
          fail_q  <= 1'b0;
          oor_q   <= 1'b0;
          cnt_q   <= CNT_W'(SAMPLE_CYCLES - 1);
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          fail_q <= fail_q | eye_early[lane_q] | eye_late[lane_q];
          oor_q  <= oor_q | delay_out_of_range[lane_q];
          if (cnt_q == '0) state_q <= S_EVAL;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        S_EVAL: begin
          open_q  <= open_d;
          first_q <= first_d;
          last_q  <= last_d;
          if (found_c) begin
            res_center_q <= center_c;
            res_width_q  <= width_c;
            res_err_q    <= (width_c < (TAP_W+1)'(WIN_FLOOR));
            load_q       <= lane_onehot(lane_q);
            state_q      <= S_CLOAD;
          end else if (sweep_end_c) begin
            res_center_q <= '0;
            res_width_q  <= '0;
            res_err_q    <= 1'b1;
            load_q       <= lane_onehot(lane_q);
            state_q      <= S_CLOAD;
          end else begin
            move_q  <= lane_onehot(lane_q);
            state_q <= S_STEP;
          end
        end
        S_CLOAD: begin
          load_q <= '0;
          if (res_center_q == '0) begin
            state_q <= S_NEXT;
          end else begin
            move_q   <= lane_onehot(lane_q);
            mv_cnt_q <= res_center_q;
            state_q  <= S_CMOVE;
          end
        end
        // Each centring pulse is one cycle high, one cycle low.
        S_CMOVE: begin
          if (|move_q) begin
            move_q   <= '0;
            mv_cnt_q <= mv_cnt_q - TAP_W'(1);
          end else if (mv_cnt_q == '0) begin
            state_q <= S_NEXT;
          end else begin
            move_q <= lane_onehot(lane_q);
          end
        end
        S_NEXT: begin
          center_q[lane_q*TAP_W +: TAP_W]     <= res_center_q;
          width_q[lane_q*(TAP_W+1) +: TAP_W+1] <= res_width_q;
          err_q[lane_q]                       <= res_err_q;
          if (lane_q == LANE_W'(NUM_LANES - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            lane_q  <= lane_q + LANE_W'(1);
            tap_q   <= '0;
            open_q  <= 1'b0;
            load_q  <= lane_onehot(lane_q + LANE_W'(1));
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign delay_line_move      = move_q;
  assign delay_line_direction = move_q;
  assign delay_line_load      = load_q;
  assign eye_clear_flags      = clear_q;
  assign lane_center          = center_q;
  assign lane_width           = width_q;
  assign lane_err             = err_q;

endmodule

// File: doc/iod_rd_eye_trainer.md
# iod_rd_eye_trainer

Multi-lane read-eye training controller for the DDR4 PHY read-training IOD lanes. It sweeps each lane's dynamic RX delay line with the IOD delay-line controls, `DELAY_LINE_MOVE`, `DELAY_LINE_DIRECTION` and `DELAY_LINE_LOAD`. At every tap it clears and samples the eye-monitor EARLY/LATE flags, then locates the first contiguous passing window. Finally it parks each lane at the window centre. It sits on `FAB_CLK` between the PHY sequencer and the per-lane IOD delay/eye-monitor pins, and it generalises single-lane manual training to `NUM_LANES` automatic lanes.

## Interface
Parameters:
- `NUM_LANES`, default 2: number of IOD lanes trained, 1..16.
- `TAP_W`, default 7: tap counter width.
- `MAX_TAP`, default 127: last tap swept; must be < 2^`TAP_W`.
- `SETTLE_CYCLES`, default 8: wait after LOAD/MOVE before clearing flags; must be ≥ 1.
- `SAMPLE_CYCLES`, default 16: flag observation window per tap; must be ≥ 1.
- `MIN_WIN`, default 4: minimum passing-window width. Used only with the macro below.

Ports:
- `FAB_CLK` in 1: fabric clock. All I/O is synchronous to it.
- `ARST_N` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins training of all lanes. It is ignored while `busy`=1.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse when the last lane finishes.
- `delay_line_move` out `NUM_LANES`: per-lane MOVE pulse.
- `delay_line_direction` out `NUM_LANES`: per-lane DIRECTION. It is 1 (increment) whenever MOVE is high.
- `delay_line_load` out `NUM_LANES`: per-lane LOAD pulse. LOAD returns the line to tap 0.
- `eye_clear_flags` out `NUM_LANES`: per-lane EYE_MONITOR_CLEAR_FLAGS pulse.
- `eye_early` in `NUM_LANES`: EYE_MONITOR_EARLY per lane.
- `eye_late` in `NUM_LANES`: EYE_MONITOR_LATE per lane.
- `delay_out_of_range` in `NUM_LANES`: DELAY_LINE_OUT_OF_RANGE per lane.
- `lane_center` out `NUM_LANES*TAP_W`: final tap per lane. Lane i occupies bits [i*TAP_W +: TAP_W].
- `lane_width` out `NUM_LANES*(TAP_W+1)`: passing-window width per lane.
- `lane_err` out `NUM_LANES`: lane found no valid window.

## Operation
- Lanes are trained sequentially, lane 0 first. Only the active lane's control bits can be high; all other control outputs are 0.
- States:
  - IDLE
  - LOAD: LOAD high for 1 cycle; tap=0.
  - SETTLE: wait `SETTLE_CYCLES` cycles.
  - CLEAR: clear_flags high for 1 cycle.
  - SAMPLE: `SAMPLE_CYCLES` cycles; fail |= early|late.
  - EVAL: 1 cycle.
  - STEP: MOVE high for 1 cycle, then tap += 1, then go to SETTLE.
  - CLOAD: LOAD high for 1 cycle.
  - CMOVE
  - NEXT
  - DONE
- EVAL at tap t:
  - Pass with no window open: first=t, last=t, window open.
  - Pass with window open: last=t.
  - Fail with window open: window closed; go to CLOAD.
  - Fail with no window open: no change.
  - If the window is still open and (t==`MAX_TAP` or `delay_out_of_range` was seen during SAMPLE): sweep ends; go to CLOAD.
  - Otherwise, if no window and sweep end: set `lane_err`, center=0, width=0, go to CLOAD.
  - Otherwise go to STEP.
- Results:
  - width = last − first + 1, computed at `TAP_W`+1 bits.
  - center = (first + last) >> 1, with the sum computed at `TAP_W`+1 bits and floored.
- CLOAD/CMOVE: after the LOAD, issue exactly `center` MOVE pulses. Each pulse is 1 cycle high followed by 1 cycle low. center=0 issues no pulses.
- NEXT: write results to the lane's output slice and advance the lane index. After the last lane, go to DONE.
- DONE: `done`=1 for 1 cycle, `busy`=0, then IDLE.
- Results and `lane_err` hold until the next accepted `start`. At that start they clear to 0 in the cycle `busy` rises.
- Only the first passing window counts; later windows are never examined.

## Timing
- Reset value of every output is 0, including all result buses. `ARST_N` low mid-operation aborts the FSM to IDLE immediately, and the MOVE/LOAD/CLEAR outputs drop asynchronously.
- `start` at cycle 0: `busy`=1 and LOAD high at cycle 1.
- Per-tap cost: 1 (LOAD or MOVE) + `SETTLE_CYCLES` + 1 + `SAMPLE_CYCLES` + 1 cycles.
- Centering cost: 1 + 2·center cycles. NEXT takes 1 cycle.
- Flags that arrive in the SETTLE or CLEAR cycles are ignored. Only flags seen during SAMPLE count.
- `delay_out_of_range` ends the sweep at the EVAL that follows it. The EVAL result for that tap is still applied first.

## Configuration
- `IOD_RD_TRAIN_MIN_WIN_EN`:
  - Defined: a window with width < `MIN_WIN` sets `lane_err`. center and width are still reported.
  - Undefined: any width ≥ 1 is accepted and `MIN_WIN` is unused.

## Test plan
Bench settings: `NUM_LANES`=2, `SETTLE_CYCLES`=4, `SAMPLE_CYCLES`=8, `MAX_TAP`=127.
- Lane model passes at taps 20..40 on lane 0 and 50..60 on lane 1 -> centers 30/55, widths 21/11, `lane_err`=00. Lane 0 receives exactly 30 MOVE pulses after CLOAD.
- Lane 0 passes at 100..127 (window still open at `MAX_TAP`) -> center 113, width 28, no error.
- Lane 1 never passes -> `lane_err`=10, lane 1 center 0, width 0, `done` pulses once.
- Passing windows 5..6 and 30..50 -> only the first is used: center 5, width 2. With `IOD_RD_TRAIN_MIN_WIN_EN`, `lane_err` bit set.
- `delay_out_of_range` asserted at tap 70 while passing from 60 -> center 65, width 11. A second `start` pulse while `busy` -> ignored.
- `ARST_N` low during the lane 1 SAMPLE state -> all outputs 0 at once. A new `start` then retrains from lane 0 with correct results.
